// File: rtl/matmul4x4_sequencer.sv
// matmul4x4_sequencer: walks (i, j, k) for an N x N matrix product and
// drives operand selects, MAC strobes and result writes with a start/done handshake.
module matmul4x4_sequencer #(
  parameter int IDX_W = 2,
  parameter int LAT   = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               STALL,
  output logic [IDX_W-1:0]   ROW_SEL,
  output logic [IDX_W-1:0]   COL_SEL,
  output logic [IDX_W-1:0]   K_SEL,
  output logic               MAC_EN,
  output logic               MAC_CLR,
  output logic               RES_WE,
  output logic [2*IDX_W-1:0] RES_ADDR,
  output logic               BUSY,
  output logic               DONE
);
  localparam int AW = 2 * IDX_W;
  localparam logic [IDX_W-1:0] MAXI = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_e;

  typedef struct packed {
    logic          en;
    logic          clr;
    logic          lk;
    logic [AW-1:0] addr;
  } stage_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic [IDX_W-1:0] k_q, k_d;
  stage_t           pipe_q [LAT];
  stage_t           pipe_d [LAT];
  stage_t           head;
  stage_t           tail;
  logic             we_q, we_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic             hold;
  logic             issue;
  logic             last;
  logic             pend;

  assign hold  = STALL && (state_q == RUN || state_q == DRAIN);
  assign issue = (state_q == RUN) && !STALL;
  assign last  = (i_q == MAXI) && (j_q == MAXI) && (k_q == MAXI);
  assign tail  = pipe_q[LAT-1];

  always_comb begin
    head      = '0;
    head.en   = issue;
    head.clr  = issue && (k_q == '0);
    head.lk   = issue && (k_q == MAXI);
    head.addr = {i_q, j_q};
  end

  always_comb begin
    pend = 1'b0;
    for (int s = 0; s < LAT; s++) pend = pend | pipe_q[s].en;
  end

  // Delay line matches operand latency; the extra write stage covers the accumulator register.
  always_comb begin
    pipe_d  = pipe_q;
    we_d    = we_q;
    waddr_d = waddr_q;
    if (!hold) begin
      pipe_d[0] = head;
      for (int s = 1; s < LAT; s++) pipe_d[s] = pipe_q[s-1];
      we_d = tail.en && tail.lk;
      if (tail.en && tail.lk) waddr_d = tail.addr;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: if (START) state_d = RUN;
      RUN: begin
        if (issue) begin
          if (last) begin
            state_d = DRAIN;
          end else begin
            k_d = k_q + 1'b1;
            if (k_q == MAXI) begin
              j_d = j_q + 1'b1;
              if (j_q == MAXI) i_d = i_q + 1'b1;
            end
          end
        end
      end
      DRAIN: begin
        if (!hold && we_q && !pend) begin
          state_d = FIN;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      FIN:     state_d = START ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      for (int s = 0; s < LAT; s++) pipe_q[s] <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      pipe_q  <= pipe_d;
    end
  end

  always_comb begin
    MAC_EN  = tail.en && !hold;
    MAC_CLR = tail.clr && !hold;
    RES_WE  = we_q && !hold;
    BUSY    = (state_q == RUN) || (state_q == DRAIN);
    DONE    = (state_q == FIN);
  end

  assign ROW_SEL  = i_q;
  assign COL_SEL  = j_q;
  assign K_SEL    = k_q;
  assign RES_ADDR = waddr_q;

endmodule

// File: tb/tb_matmul4x4_sequencer.sv
// tb_matmul4x4_sequencer: cycle timeline checks on LAT=1 and LAT=3 builds,
// plus a behavioural datapath feeding a write scoreboard on the LAT=1 build.
module tb_matmul4x4_sequencer;
  logic        CLK, RST, START, STALL;
  logic [1:0]  ROW1, COL1, K1, ROW3, COL3, K3;
  logic        EN1, CLR1, WE1, DONE1, BUSY1;
  logic        EN3, CLR3, WE3, DONE3, BUSY3;
  logic [3:0]  AD1, AD3;
  logic [14:0] obs1, obs3, e1, e3;
  int          errors, checks;
  int          A [4][4];
  int          B [4][4];
  int          prod, acc;

  typedef struct {
    logic [3:0] addr;
    int         val;
  } wr_t;
  wr_t sbq [$];
  wr_t sb_w;

  matmul4x4_sequencer #(.IDX_W(2), .LAT(1)) u_dut (
    .CLK(CLK), .RST(RST), .START(START), .STALL(STALL),
    .ROW_SEL(ROW1), .COL_SEL(COL1), .K_SEL(K1),
    .MAC_EN(EN1), .MAC_CLR(CLR1), .RES_WE(WE1), .RES_ADDR(AD1),
    .BUSY(BUSY1), .DONE(DONE1)
  );

  matmul4x4_sequencer #(.IDX_W(2), .LAT(3)) u_dut3 (
    .CLK(CLK), .RST(RST), .START(START), .STALL(STALL),
    .ROW_SEL(ROW3), .COL_SEL(COL3), .K_SEL(K3),
    .MAC_EN(EN3), .MAC_CLR(CLR3), .RES_WE(WE3), .RES_ADDR(AD3),
    .BUSY(BUSY3), .DONE(DONE3)
  );

  assign obs1 = {ROW1, COL1, K1, EN1, CLR1, WE1, WE1 ? AD1 : 4'd0, DONE1, BUSY1};
  assign obs3 = {ROW3, COL3, K3, EN3, CLR3, WE3, WE3 ? AD3 : 4'd0, DONE3, BUSY3};

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Datapath model: registered product (LAT=1), accumulator, scoreboard on writes.
  always @(negedge CLK) begin
    if (WE1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got addr=%0d val=%0d required no write", AD1, acc);
      end else begin
        sb_w = sbq.pop_front();
        if (AD1 !== sb_w.addr || acc !== sb_w.val) begin
          errors++;
          $display("FAIL sb_write got addr=%0d val=%0d required addr=%0d val=%0d",
                   AD1, acc, sb_w.addr, sb_w.val);
        end
      end
    end
    if (EN1) acc <= CLR1 ? prod : acc + prod;
    if (!(STALL && BUSY1)) prod <= A[ROW1][K1] * B[K1][COL1];
  end

  // Expected outputs t cycles after the START edge for an unstalled run.
  function automatic logic [14:0] exp_vec(int t, int L, bit st);
    logic [1:0] r, cc, k;
    logic       en, clr, we, dn, bz;
    logic [3:0] ad;
    int         n;
    r = 2'd0; cc = 2'd0; k = 2'd0; ad = 4'd0;
    if (t >= 1 && t <= 64) begin
      n  = t - 1;
      r  = n[5:4];
      cc = n[3:2];
      k  = n[1:0];
    end else if (t >= 65 && t <= L + 65) begin
      r = 2'd3; cc = 2'd3; k = 2'd3;
    end
    en  = (t >= 1 + L) && (t <= 64 + L);
    clr = en && ((t - 1 - L) % 4 == 0);
    we  = (t >= L + 5) && (t <= L + 65) && ((t - L - 5) % 4 == 0);
    if (we) ad = 4'((t - L - 5) / 4);
    dn  = (t == L + 66);
    bz  = (t >= 1) && (t <= L + 65);
    if (st) begin
      en = 1'b0; clr = 1'b0; we = 1'b0; ad = 4'd0;
    end
    return {r, cc, k, en, clr, we, ad, dn, bz};
  endfunction

  task automatic load_ib();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        A[r][c] = (r == c) ? 1 : 0;
        B[r][c] = 4 * r + c;
      end
  endtask

  task automatic load_twos();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        A[r][c] = 2;
        B[r][c] = 2;
      end
  endtask

  task automatic push_exp();
    wr_t w;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        w.addr = 4'(4 * r + c);
        w.val  = 0;
        for (int k = 0; k < 4; k++) w.val += A[r][k] * B[k][c];
        sbq.push_back(w);
      end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    #2;
    checks += 2;
    if (obs1 !== 15'd0 || AD1 !== 4'd0) begin
      errors++;
      $display("FAIL reset_lat1 got=%h addr=%0d required=0", obs1, AD1);
    end
    if (obs3 !== 15'd0 || AD3 !== 4'd0) begin
      errors++;
      $display("FAIL reset_lat3 got=%h addr=%0d required=0", obs3, AD3);
    end
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    checks++;
    if (obs1 !== 15'd0 || obs3 !== 15'd0) begin
      errors++;
      $display("FAIL reset_idle got=%h/%h required=0", obs1, obs3);
    end
  endtask

  task automatic test_basic();
    load_ib();
    push_exp();
    @(posedge CLK); #1; START = 1'b1;
    for (int c = 1; c <= 74; c++) begin
      @(posedge CLK); #1; START = 1'b0; #1;
      e1 = exp_vec(c, 1, 1'b0);
      e3 = exp_vec(c, 3, 1'b0);
      checks += 2;
      if (obs1 !== e1) begin
        errors++;
        $display("FAIL basic_lat1 c=%0d got=%h required=%h", c, obs1, e1);
      end
      if (obs3 !== e3) begin
        errors++;
        $display("FAIL basic_lat3 c=%0d got=%h required=%h", c, obs3, e3);
      end
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL basic_writes got %0d missing required 0", sbq.size());
    end
  endtask

  task automatic test_stall();
    int nst;
    bit st;
    nst = 0;
    load_ib();
    push_exp();
    @(posedge CLK); #1; START = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(posedge CLK); #1;
      START = 1'b0;
      st    = (c >= 20 && c <= 24);
      STALL = st;
      #1;
      e1 = exp_vec(c - nst, 1, st);
      e3 = exp_vec(c - nst, 3, st);
      checks += 2;
      if (obs1 !== e1) begin
        errors++;
        $display("FAIL stall_lat1 c=%0d got=%h required=%h", c, obs1, e1);
      end
      if (obs3 !== e3) begin
        errors++;
        $display("FAIL stall_lat3 c=%0d got=%h required=%h", c, obs3, e3);
      end
      if (st) nst++;
    end
    STALL = 1'b0;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL stall_writes got %0d missing required 0", sbq.size());
    end
  endtask

  task automatic test_ignored_start();
    load_twos();
    push_exp();
    @(posedge CLK); #1; START = 1'b1; STALL = 1'b1;
    for (int c = 1; c <= 74; c++) begin
      @(posedge CLK); #1;
      STALL = 1'b0;
      START = (c == 30);
      #1;
      e1 = exp_vec(c, 1, 1'b0);
      e3 = exp_vec(c, 3, 1'b0);
      checks += 2;
      if (obs1 !== e1) begin
        errors++;
        $display("FAIL ignstart_lat1 c=%0d got=%h required=%h", c, obs1, e1);
      end
      if (obs3 !== e3) begin
        errors++;
        $display("FAIL ignstart_lat3 c=%0d got=%h required=%h", c, obs3, e3);
      end
    end
    START = 1'b0;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL ignstart_writes got %0d missing required 0", sbq.size());
    end
  endtask

  task automatic test_back_to_back();
    load_ib();
    push_exp();
    push_exp();
    @(posedge CLK); #1; START = 1'b1;
    for (int c = 1; c <= 145; c++) begin
      @(posedge CLK); #1;
      START = (c <= 100);
      #1;
      e1 = exp_vec((c <= 67) ? c : c - 67, 1, 1'b0);
      e3 = exp_vec((c <= 69) ? c : c - 69, 3, 1'b0);
      checks += 2;
      if (obs1 !== e1) begin
        errors++;
        $display("FAIL b2b_lat1 c=%0d got=%h required=%h", c, obs1, e1);
      end
      if (obs3 !== e3) begin
        errors++;
        $display("FAIL b2b_lat3 c=%0d got=%h required=%h", c, obs3, e3);
      end
    end
    START = 1'b0;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL b2b_writes got %0d missing required 0", sbq.size());
    end
  endtask

  task automatic test_reset_midrun();
    load_ib();
    push_exp();
    @(posedge CLK); #1; START = 1'b1;
    for (int c = 1; c <= 39; c++) begin
      @(posedge CLK); #1; START = 1'b0; #1;
      e1 = exp_vec(c, 1, 1'b0);
      checks++;
      if (obs1 !== e1) begin
        errors++;
        $display("FAIL prereset_lat1 c=%0d got=%h required=%h", c, obs1, e1);
      end
    end
    @(posedge CLK); #3;
    RST = 1'b1;
    #1;
    checks += 2;
    if (obs1 !== 15'd0 || AD1 !== 4'd0) begin
      errors++;
      $display("FAIL midreset_lat1 got=%h addr=%0d required=0", obs1, AD1);
    end
    if (obs3 !== 15'd0 || AD3 !== 4'd0) begin
      errors++;
      $display("FAIL midreset_lat3 got=%h addr=%0d required=0", obs3, AD3);
    end
    sbq.delete();
    repeat (2) @(posedge CLK);
    #3; RST = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(posedge CLK); #2;
      checks++;
      if (obs1 !== 15'd0 || obs3 !== 15'd0) begin
        errors++;
        $display("FAIL postreset_quiet c=%0d got=%h/%h required=0", c, obs1, obs3);
      end
    end
    load_twos();
    push_exp();
    @(posedge CLK); #1; START = 1'b1;
    for (int c = 1; c <= 74; c++) begin
      @(posedge CLK); #1; START = 1'b0; #1;
      e1 = exp_vec(c, 1, 1'b0);
      e3 = exp_vec(c, 3, 1'b0);
      checks += 2;
      if (obs1 !== e1) begin
        errors++;
        $display("FAIL rerun_lat1 c=%0d got=%h required=%h", c, obs1, e1);
      end
      if (obs3 !== e3) begin
        errors++;
        $display("FAIL rerun_lat3 c=%0d got=%h required=%h", c, obs3, e3);
      end
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL rerun_writes got %0d missing required 0", sbq.size());
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    prod   = 0;
    acc    = 0;
    RST    = 1'b1;
    START  = 1'b0;
    STALL  = 1'b0;
    load_ib();
    test_reset();
    test_basic();
    test_stall();
    test_ignored_start();
    test_back_to_back();
    test_reset_midrun();
    repeat (2) @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
